phy_rx_lane_deskew_ctrl: RTL and testbench

- Lane-alignment controller for the two-lane PHY receiver.
- Sits between the two serial-to-parallel converters and the two 8:32 muxes, all on clk_4f.
- Replaces the fixed two-cycle lane-1 delay:
  - measures inter-lane skew at start of traffic;
  - delays the leading lane by the measured amount;
  - releases aligned byte streams to unstriping only while locked.
- Flags skew beyond range and drops lock on loss of either lane.

---
 rtl/phy_pkg.sv | 15 +
 rtl/phy_rx_lane_deskew_ctrl_if.sv | 39 +++
 rtl/phy_rx_delay_line.sv | 45 ++++
 rtl/phy_rx_lane_deskew_ctrl.sv | 165 ++++++++++++++++
 tb/tb_phy_rx_lane_deskew_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/phy_pkg.sv
// Shared types and defaults for the two-lane PHY receive path.
// Lane-alignment FSM encoding lives here so every stage agrees on it.
package phy_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_SKEW = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

endpackage

// File: rtl/phy_rx_lane_deskew_ctrl_if.sv
// Lane byte streams into and aligned streams out of the deskew controller.
// master = upstream converters / sink, slave = deskew controller.
interface phy_rx_lane_deskew_ctrl_if #(
  parameter int DATA_W = phy_pkg::DEF_DATA_W,
  parameter int SKEW_W = 3
) ();

  logic [DATA_W-1:0] data_in0;
  logic              valid_in0;
  logic              active_in0;
  logic [DATA_W-1:0] data_in1;
  logic              valid_in1;
  logic              active_in1;
  logic [DATA_W-1:0] data_out0;
  logic              valid_out0;
  logic [DATA_W-1:0] data_out1;
  logic              valid_out1;
  logic              aligned;
  logic [SKEW_W-1:0] skew;
  logic              lead_lane;
  logic              skew_err;

  modport master (
    output data_in0, valid_in0, active_in0,
    output data_in1, valid_in1, active_in1,
    input  data_out0, valid_out0,
    input  data_out1, valid_out1,
    input  aligned, skew, lead_lane, skew_err
  );

  modport slave (
    input  data_in0, valid_in0, active_in0,
    input  data_in1, valid_in1, active_in1,
    output data_out0, valid_out0,
    output data_out1, valid_out1,
    output aligned, skew, lead_lane, skew_err
  );

endinterface

// File: rtl/phy_rx_delay_line.sv
// Free-running {valid, data} shift register with a runtime tap.
// Tap 0 is the live input; tap d is the input from d cycles ago.
module phy_rx_delay_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int TAP_W  = 3
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAP_W-1:0]  tap,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W:0] sr_q [DEPTH];
  logic [DATA_W:0] sr_d [DEPTH];
  logic [DATA_W:0] sel;

  always_comb begin
    sr_d[0] = {in_valid, in_data};
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_comb begin
    sel = {in_valid, in_data};
    for (int i = 1; i <= DEPTH; i++) begin
      if (tap == TAP_W'(i)) sel = sr_q[i-1];
    end
  end

  assign out_valid = sel[DATA_W];
  assign out_data  = sel[DATA_W-1:0];

  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) sr_q[i] <= '0;
      else       sr_q[i] <= sr_d[i];
    end
  end

endmodule

// File: rtl/phy_rx_lane_deskew_ctrl.sv
// Measures inter-lane skew at start of traffic, delays the leading
// lane to match and releases aligned byte pairs while locked.
module phy_rx_lane_deskew_ctrl
  import phy_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_SKEW = DEF_MAX_SKEW
) (
  input logic                       clk_4f,
  input logic                       reset,
  phy_rx_lane_deskew_ctrl_if.slave  bus
);

  localparam int SKEW_W = $clog2(MAX_SKEW + 1);

  state_t            state_q, state_d;
  logic [SKEW_W-1:0] cnt_q, cnt_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic              lead_q, lead_d;
  logic              vin0_q, vin0_d;
  logic              vin1_q, vin1_d;
  logic [DATA_W-1:0] dout0_q, dout0_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic              vout0_q, vout0_d;
  logic              vout1_q, vout1_d;
  logic              aligned_q, aligned_d;
  logic              err_q, err_d;

  logic              rise0, rise1, both;
  logic [SKEW_W-1:0] sel0, sel1;
  logic              tap0_v, tap1_v;
  logic [DATA_W-1:0] tap0_d, tap1_d;
  logic              lock;

  always_comb begin
    vin0_d  = bus.valid_in0;
    vin1_d  = bus.valid_in1;
    rise0   = bus.valid_in0 & ~vin0_q;
    rise1   = bus.valid_in1 & ~vin1_q;
    both    = bus.active_in0 & bus.active_in1;
    state_d = state_q;
    cnt_d   = cnt_q;
    skew_d  = skew_q;
    lead_d  = lead_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        skew_d = '0;
        lead_d = 1'b0;
        if (both && rise0 && rise1) begin
          state_d = ST_LOCKED;
        end else if (both && (rise0 || rise1)) begin
          state_d = ST_MEASURE;
          cnt_d   = SKEW_W'(1);
          lead_d  = rise1;
        end
      end
      ST_MEASURE: begin
        // further rises on the leading lane are deliberately ignored
        if (!both) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          lead_d  = 1'b0;
        end else if (lead_q ? rise0 : rise1) begin
          state_d = ST_LOCKED;
          skew_d  = cnt_q;
        end else if (cnt_q == SKEW_W'(MAX_SKEW)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + SKEW_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!both) begin
          state_d = ST_IDLE;
          skew_d  = '0;
          lead_d  = 1'b0;
        end
      end
      ST_ERR: begin
        if (!bus.active_in0 && !bus.active_in1) begin
          state_d = ST_IDLE;
          lead_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lock      = (state_d == ST_LOCKED);
    sel0      = lead_d ? '0 : skew_d;
    sel1      = lead_d ? skew_d : '0;
    vout0_d   = lock & tap0_v;
    vout1_d   = lock & tap1_v;
    dout0_d   = lock ? tap0_d : '0;
    dout1_d   = lock ? tap1_d : '0;
    aligned_d = lock;
    err_d     = (state_d == ST_ERR);
  end

  phy_rx_delay_line #(
    .DATA_W(DATA_W), .DEPTH(MAX_SKEW), .TAP_W(SKEW_W)
  ) u_dl0 (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .in_valid (bus.valid_in0),
    .in_data  (bus.data_in0),
    .tap      (sel0),
    .out_valid(tap0_v),
    .out_data (tap0_d)
  );

  phy_rx_delay_line #(
    .DATA_W(DATA_W), .DEPTH(MAX_SKEW), .TAP_W(SKEW_W)
  ) u_dl1 (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .in_valid (bus.valid_in1),
    .in_data  (bus.data_in1),
    .tap      (sel1),
    .out_valid(tap1_v),
    .out_data (tap1_d)
  );

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      skew_q    <= '0;
      lead_q    <= 1'b0;
      vin0_q    <= 1'b0;
      vin1_q    <= 1'b0;
      dout0_q   <= '0;
      dout1_q   <= '0;
      vout0_q   <= 1'b0;
      vout1_q   <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skew_q    <= skew_d;
      lead_q    <= lead_d;
      vin0_q    <= vin0_d;
      vin1_q    <= vin1_d;
      dout0_q   <= dout0_d;
      dout1_q   <= dout1_d;
      vout0_q   <= vout0_d;
      vout1_q   <= vout1_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
    end
  end

  assign bus.data_out0  = dout0_q;
  assign bus.valid_out0 = vout0_q;
  assign bus.data_out1  = dout1_q;
  assign bus.valid_out1 = vout1_q;
  assign bus.aligned    = aligned_q;
  assign bus.skew       = skew_q;
  assign bus.lead_lane  = lead_q;
  assign bus.skew_err   = err_q;

endmodule

// File: tb/tb_phy_rx_lane_deskew_ctrl.sv
// Randomized lane-skew scenarios; expected byte pairs are queued per
// scenario and popped by an independent output monitor.
module tb_phy_rx_lane_deskew_ctrl;

  localparam int DW = 8;
  localparam int MS = 4;
  localparam int SW = $clog2(MS + 1);

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;

  phy_rx_lane_deskew_ctrl_if #(.DATA_W(DW), .SKEW_W(SW)) bus ();

  phy_rx_lane_deskew_ctrl #(.DATA_W(DW), .MAX_SKEW(MS)) dut (
    .clk_4f(clk_4f),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_4f = ~clk_4f;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented output pair must be the next expected one
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk_4f);
      #1;
      if (bus.valid_out0 === 1'b1 || bus.valid_out1 === 1'b1) begin
        check("vout0", bus.valid_out0, 1);
        check("vout1", bus.valid_out1, 1);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none at %0t",
                   {bus.data_out0, bus.data_out1}, $time);
        end else begin
          e = sb.pop_front();
          check("pair", {bus.data_out0, bus.data_out1}, e);
        end
      end
    end
  end

  function automatic logic [23:0] all_outs();
    return {bus.valid_out0, bus.valid_out1, bus.data_out0, bus.data_out1,
            bus.aligned, bus.skew, bus.lead_lane, bus.skew_err};
  endfunction

  task automatic drive_idle(input logic act);
    bus.active_in0 = act;
    bus.active_in1 = act;
    bus.valid_in0  = 1'b0;
    bus.valid_in1  = 1'b0;
    bus.data_in0   = '0;
    bus.data_in1   = '0;
  endtask

  task automatic drop_all();
    @(negedge clk_4f);
    drive_idle(1'b0);
    repeat (2) @(negedge clk_4f);
  endtask

  // Lead lane starts at j=0, lag lane s cycles later, same valid pattern.
  task automatic run_scn(input bit lead, input int s, input logic [7:0] f0,
                         input logic [7:0] f1, input int rst_at);
    bit          pat [16];
    logic [7:0]  a   [16];
    logic [7:0]  b   [16];
    int          n, off0, off1, total, i0, i1;
    n = $urandom_range(8, 14);
    for (int i = 0; i < 16; i++) begin
      pat[i] = (i == 0) || ($urandom_range(0, 3) != 0);
      a[i]   = (i == 0) ? f0 : 8'($urandom);
      b[i]   = (i == 0) ? f1 : 8'($urandom);
    end
    off0  = lead ? s : 0;
    off1  = lead ? 0 : s;
    total = n + s + MS + 3;
    if (s <= MS) begin
      for (int i = 0; i < n; i++) if (pat[i]) sb.push_back({a[i], b[i]});
    end
    @(negedge clk_4f);
    drive_idle(1'b1);
    for (int j = 0; j < total; j++) begin
      @(negedge clk_4f);
      if (j == rst_at) begin
        reset = 1'b1;
        sb.delete();
        drive_idle(1'b0);
        @(negedge clk_4f);
        check("reset_mid_lock", all_outs(), 0);
        reset = 1'b0;
        return;
      end
      if (s <= MS && j == s + 1) begin
        check("lat_valid", bus.valid_out0 & bus.valid_out1, 1);
        check("lat_data", {bus.data_out0, bus.data_out1}, {a[0], b[0]});
      end
      i0 = j - off0;
      i1 = j - off1;
      bus.valid_in0 = (i0 >= 0 && i0 < n) ? pat[i0] : 1'b0;
      bus.data_in0  = (i0 >= 0 && i0 < n) ? a[i0] : 8'($urandom);
      bus.valid_in1 = (i1 >= 0 && i1 < n) ? pat[i1] : 1'b0;
      bus.data_in1  = (i1 >= 0 && i1 < n) ? b[i1] : 8'($urandom);
    end
    @(negedge clk_4f);
    if (s <= MS) begin
      check("aligned", bus.aligned, 1);
      check("skew", bus.skew, s);
      check("lead_lane", bus.lead_lane, (s == 0) ? 0 : lead);
      check("no_err", bus.skew_err, 0);
    end else begin
      check("skew_err", bus.skew_err, 1);
      check("err_not_aligned", bus.aligned, 0);
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    bit lead;
    int s;
    drive_idle(1'b0);
    repeat (3) @(negedge clk_4f);
    check("reset_state", all_outs(), 0);
    reset = 1'b0;

    run_scn(1'b0, 0, 8'hBC, 8'hBC, -1);
    drop_all();
    run_scn(1'b0, 2, 8'hA0, 8'hB0, -1);
    drop_all();
    run_scn(1'b1, MS, 8'hC0, 8'hD0, -1);
    drop_all();

    run_scn(1'b1, MS + 1, 8'hE0, 8'hF0, -1);
    @(negedge clk_4f);
    check("err_held", bus.skew_err, 1);
    drop_all();
    check("err_cleared", bus.skew_err, 0);

    run_scn(1'b0, 3, 8'h31, 8'h32, -1);
    bus.active_in1 = 1'b0;
    @(negedge clk_4f);
    bus.active_in1 = 1'b1;
    check("drop_aligned", bus.aligned, 0);
    check("drop_valid", {bus.valid_out0, bus.valid_out1}, 0);
    check("drop_skew", bus.skew, 0);
    run_scn(1'b1, 1, 8'h41, 8'h42, -1);
    drop_all();

    run_scn(1'b0, 2, 8'h51, 8'h52, 7);
    run_scn(1'b0, 2, 8'h51, 8'h52, -1);
    drop_all();

    repeat (6) begin
      lead = 1'($urandom_range(0, 1));
      s    = $urandom_range(0, MS);
      run_scn(lead, s, 8'($urandom), 8'($urandom), -1);
      drop_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
